// File: rtl/fb_pkg.sv
// Shared constants, types and FSM encodings for the frame buffer pack writer.
package fb_pkg;

  localparam logic [21:0] BASE_A         = 22'h100000;
  localparam logic [21:0] BASE_B         = 22'h200000;
  localparam int          WORDS_PER_LINE = 40;
  localparam int          LINES          = 480;
  localparam int          PIX_PER_WORD   = 16;
  localparam int          FIFO_DEPTH     = 4;

  typedef logic [127:0] fb_word_t;
  typedef logic [21:0]  fb_addr_t;

  typedef struct packed {
    fb_addr_t addr;
    fb_word_t data;
  } fb_entry_t;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} fb_in_state_e;
  typedef enum logic       {WIDLE, WREQ}             fb_wr_state_e;

  function automatic fb_word_t fb_replicate(input logic [7:0] color);
    return {PIX_PER_WORD{color}};
  endfunction

endpackage

// File: rtl/fb_pack_writer_if.sv
// Pixel stream and SDRAM write port of the pack writer; master is the writer side.
interface fb_pack_writer_if;
  import fb_pkg::*;

  logic     pix_valid;
  logic [7:0] pix_index;
  logic     pix_ready;
  logic     rd_busy;
  logic     sdram_wr;
  fb_addr_t sdram_addr;
  fb_word_t sdram_data;
  logic     sdram_ac;

  modport master (
    input  pix_valid, pix_index, rd_busy, sdram_ac,
    output pix_ready, sdram_wr, sdram_addr, sdram_data
  );

  modport slave (
    output pix_valid, pix_index, rd_busy, sdram_ac,
    input  pix_ready, sdram_wr, sdram_addr, sdram_data
  );
endinterface

// File: rtl/fb_word_fifo.sv
// Small synchronous FIFO of {address, packed word} entries with a whole-queue flush.
module fb_word_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push,
  input  fb_entry_t push_entry,
  input  logic      pop,
  input  logic      flush,
  output fb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  fb_entry_t      mem_q [DEPTH];
  fb_entry_t      mem_d [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fb_pack_writer.sv
// Packs 16 palette indices per 128-bit word and writes them into the back frame buffer.
// FB_PACK_WRITER_CLEAR_EN adds clear_req/clear_color for internally generated fill frames.
//
// state | meaning
// IDLE  | no frame started since reset
// FILL  | accepting pixels (or generating clear words), pushing packed words
// DRAIN | final word pushed, waiting for FIFO and write port to empty
// DONE  | frame complete, waiting for the next frame_start
// WIDLE | write port idle
// WREQ  | write request held until acknowledged
module fb_pack_writer #(
  parameter fb_pkg::fb_addr_t BASE_A         = fb_pkg::BASE_A,
  parameter fb_pkg::fb_addr_t BASE_B         = fb_pkg::BASE_B,
  parameter int               WORDS_PER_LINE = fb_pkg::WORDS_PER_LINE,
  parameter int               LINES          = fb_pkg::LINES,
  parameter int               FIFO_DEPTH     = fb_pkg::FIFO_DEPTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 frame_flip,
  input  logic                 frame_start,
`ifdef FB_PACK_WRITER_CLEAR_EN
  input  logic                 clear_req,
  input  logic [7:0]           clear_color,
`endif
  fb_pack_writer_if.master     bus,
  output logic                 busy,
  output logic                 frame_done
);
  import fb_pkg::*;

  fb_in_state_e state_q, state_d;
  fb_wr_state_e wstate_q, wstate_d;
  fb_addr_t     base_q, base_d;
  logic [3:0]   px_q, px_d;
  logic [5:0]   wx_q, wx_d;
  logic [8:0]   ly_q, ly_d;
  fb_word_t     pack_q, pack_d;
  logic         wr_q, wr_d;
  fb_addr_t     addr_q, addr_d;
  fb_word_t     data_q, data_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         orphan_q, orphan_d;

  logic         push, pop, flush, full, empty, advance, clearing, pix_ok, last_word;
  fb_entry_t    push_entry, head;
  fb_addr_t     word_addr;

`ifdef FB_PACK_WRITER_CLEAR_EN
  logic         clear_q, clear_d;
  logic [7:0]   color_q, color_d;
  assign clearing = clear_q;
`else
  assign clearing = 1'b0;
`endif

  fb_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (flush),
    .head       (head),
    .full       (full),
    .empty      (empty)
  );

  assign bus.pix_ready  = (state_q == FILL) && !full && !clearing;
  assign bus.sdram_wr   = wr_q;
  assign bus.sdram_addr = addr_q;
  assign bus.sdram_data = data_q;
  assign busy           = busy_q;
  assign frame_done     = done_q;

  assign pix_ok    = bus.pix_valid && bus.pix_ready;
  assign last_word = (ly_q == 9'(LINES - 1)) && (wx_q == 6'(WORDS_PER_LINE - 1));
  assign word_addr = base_q + fb_addr_t'(ly_q) * fb_addr_t'(WORDS_PER_LINE) + fb_addr_t'(wx_q);

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    px_d       = px_q;
    wx_d       = wx_q;
    ly_d       = ly_q;
    pack_d     = pack_q;
    push       = 1'b0;
    flush      = 1'b0;
    advance    = 1'b0;
    push_entry = '{addr: word_addr, data: pack_q};
`ifdef FB_PACK_WRITER_CLEAR_EN
    clear_d    = clear_q;
    color_d    = color_q;
`endif
    // A restart discards everything not yet handed to the write port.
    if (frame_start) begin
      state_d = FILL;
      base_d  = frame_flip ? BASE_B : BASE_A;
      px_d    = '0;
      wx_d    = '0;
      ly_d    = '0;
      pack_d  = '0;
      flush   = 1'b1;
`ifdef FB_PACK_WRITER_CLEAR_EN
      clear_d = clear_req;
      color_d = clear_color;
`endif
    end else begin
      case (state_q)
        FILL: begin
          if (clearing) begin
            if (!full) begin
              push       = 1'b1;
              advance    = 1'b1;
`ifdef FB_PACK_WRITER_CLEAR_EN
              push_entry.data = fb_replicate(color_q);
`endif
            end
          end else if (pix_ok) begin
            pack_d[{px_q, 3'b000} +: 8] = bus.pix_index;
            px_d = px_q + 4'd1;
            if (px_q == 4'(PIX_PER_WORD - 1)) begin
              push            = 1'b1;
              advance         = 1'b1;
              push_entry.data = pack_d;
            end
          end
          if (advance) begin
            if (wx_q == 6'(WORDS_PER_LINE - 1)) begin
              wx_d = '0;
              ly_d = ly_q + 9'd1;
            end else begin
              wx_d = wx_q + 6'd1;
            end
            if (last_word) state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (empty && (wstate_q == WIDLE)) state_d = DONE;
        end
        default: ;
      endcase
    end
    busy_d = (state_d == FILL) || (state_d == DRAIN);
    done_d = (state_q == DRAIN) && (state_d == DONE);
  end

  // orphan marks an in-flight request whose FIFO entry was flushed, so its ack must not pop.
  always_comb begin
    wstate_d = wstate_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    data_d   = data_q;
    orphan_d = orphan_q;
    pop      = 1'b0;
    case (wstate_q)
      WIDLE: begin
        if (!empty && !bus.rd_busy && !frame_start) begin
          wstate_d = WREQ;
          wr_d     = 1'b1;
          addr_d   = head.addr;
          data_d   = head.data;
        end
      end
      WREQ: begin
        if (bus.sdram_ac) begin
          wstate_d = WIDLE;
          wr_d     = 1'b0;
          pop      = !orphan_q;
          orphan_d = 1'b0;
        end else if (frame_start) begin
          orphan_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      wstate_q <= WIDLE;
      base_q   <= '0;
      px_q     <= '0;
      wx_q     <= '0;
      ly_q     <= '0;
      pack_q   <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      orphan_q <= 1'b0;
`ifdef FB_PACK_WRITER_CLEAR_EN
      clear_q  <= 1'b0;
      color_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      wstate_q <= wstate_d;
      base_q   <= base_d;
      px_q     <= px_d;
      wx_q     <= wx_d;
      ly_q     <= ly_d;
      pack_q   <= pack_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      orphan_q <= orphan_d;
`ifdef FB_PACK_WRITER_CLEAR_EN
      clear_q  <= clear_d;
      color_q  <= color_d;
`endif
    end
  end

endmodule

// File: tb/tb_fb_pack_writer.sv
// Randomised bench for fb_pack_writer: expected writes are the frame's pixels taken 16 at a
// time and placed at consecutive word addresses from the selected base.
module tb_fb_pack_writer;
  import fb_pkg::*;

  localparam int T_LINES = 3;
  localparam int T_WORDS = T_LINES * WORDS_PER_LINE;
  localparam int T_PIX   = T_WORDS * PIX_PER_WORD;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic frame_flip = 1'b0;
  logic frame_start = 1'b0;
  logic busy, frame_done;
`ifdef FB_PACK_WRITER_CLEAR_EN
  logic       clear_req = 1'b0;
  logic [7:0] clear_color = 8'h00;
`endif

  fb_pack_writer_if bus();

  fb_pack_writer #(.LINES(T_LINES)) dut (
    .clock       (clock),
    .reset       (reset),
    .frame_flip  (frame_flip),
    .frame_start (frame_start),
`ifdef FB_PACK_WRITER_CLEAR_EN
    .clear_req   (clear_req),
    .clear_color (clear_color),
`endif
    .bus         (bus),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [149:0] got, input logic [149:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // reference model
  fb_entry_t  exp_q[$];
  logic [7:0] cur_pix[$];
  fb_addr_t   frame_base = '0;
  int         word_k = 0;

  // observed SDRAM side
  int        writes = 0;
  int        done_pulses = 0;
  bit        in_flight = 0;
  bit        stray_ac = 0;
  bit        want_first = 0;
  bit        check_clear_ready = 0;
  int        ac_min = 0;
  int        ac_max = 0;
  fb_addr_t  last_addr = '0;
  fb_addr_t  first_addr = '0;
  fb_word_t  first_data = '0;

  initial begin : responder
    fb_entry_t e;
    fb_entry_t cur;
    int        wait_cnt;
    bit        prev_rd_busy;
    cur = '0;
    wait_cnt = 0;
    prev_rd_busy = 1'b0;
    bus.sdram_ac = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        in_flight = 0;
        bus.sdram_ac = 1'b0;
      end else begin
        if (frame_done) done_pulses++;
        if (check_clear_ready) chk("clear_ready", bus.pix_ready, 1'b0);
        if (bus.sdram_ac) begin
          bus.sdram_ac = 1'b0;
          if (in_flight) begin
            chk("wr_drop", bus.sdram_wr, 1'b0);
            in_flight = 0;
          end
        end else if (bus.sdram_wr) begin
          if (!in_flight) begin
            chk("rd_busy_gate", prev_rd_busy, 1'b0);
            chk("wr_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              chk("wr_addr", bus.sdram_addr, e.addr);
              chk("wr_data", bus.sdram_data, e.data);
            end
            cur = '{addr: bus.sdram_addr, data: bus.sdram_data};
            in_flight = 1;
            writes++;
            last_addr = bus.sdram_addr;
            if (want_first) begin
              first_addr = bus.sdram_addr;
              first_data = bus.sdram_data;
              want_first = 0;
            end
            wait_cnt = $urandom_range(ac_max, ac_min);
          end else begin
            chk("wr_hold", {bus.sdram_addr, bus.sdram_data}, cur);
          end
          if (wait_cnt == 0) bus.sdram_ac = 1'b1;
          else wait_cnt--;
        end
        if (stray_ac && !bus.sdram_wr && !in_flight && !bus.sdram_ac) begin
          bus.sdram_ac = 1'b1;
          stray_ac = 0;
        end
      end
      prev_rd_busy = bus.rd_busy;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic model_push(input logic [7:0] p);
    fb_word_t w;
    cur_pix.push_back(p);
    if (cur_pix.size() == PIX_PER_WORD) begin
      for (int i = 0; i < PIX_PER_WORD; i++) w[8*i +: 8] = cur_pix[i];
      exp_q.push_back('{addr: frame_base + fb_addr_t'(word_k), data: w});
      word_k++;
      cur_pix.delete();
    end
  endtask

  task automatic send_pixel(input logic [7:0] p);
    bit ok;
    ok = 0;
    bus.pix_valid = 1'b1;
    bus.pix_index = p;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clock);
      if (bus.pix_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("pix_accept", ok, 1'b1);
    @(posedge clock);
    if (ok) model_push(p);
    #1;
    bus.pix_valid = 1'b0;
  endtask

  task automatic send_pixels(input int n, input bit seq, input bit gaps);
    for (int i = 0; i < n; i++) begin
      send_pixel(seq ? 8'(i) : 8'($urandom));
      if (gaps && $urandom_range(7, 0) == 0) cyc(1);
    end
  endtask

  task automatic start_frame(input bit flip, input bit clr);
    frame_flip  = flip;
    frame_start = 1'b1;
`ifdef FB_PACK_WRITER_CLEAR_EN
    clear_req   = clr;
`endif
    @(posedge clock);
    exp_q.delete();
    cur_pix.delete();
    word_k     = 0;
    frame_base = flip ? BASE_B : BASE_A;
    want_first = 1;
    check_clear_ready = clr;
`ifdef FB_PACK_WRITER_CLEAR_EN
    if (clr) begin
      for (int k = 0; k < T_WORDS; k++)
        exp_q.push_back('{addr: frame_base + fb_addr_t'(k), data: fb_replicate(clear_color)});
    end
`endif
    #1;
    frame_start = 1'b0;
`ifdef FB_PACK_WRITER_CLEAR_EN
    clear_req   = 1'b0;
`endif
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 0;
    for (int t = 0; t < 20000; t++) begin
      @(negedge clock);
      #1;
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    chk(tag, ok, 1'b1);
    check_clear_ready = 0;
    cyc(1);
  endtask

  task automatic wait_writes(input string tag, input int n);
    bit ok;
    ok = 0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clock);
      #1;
      if (writes >= n && !in_flight) begin
        ok = 1;
        break;
      end
    end
    chk(tag, ok, 1'b1);
    cyc(1);
  endtask

  task automatic wait_flight(input string tag);
    bit ok;
    ok = 0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clock);
      #1;
      if (in_flight) begin
        ok = 1;
        break;
      end
    end
    chk(tag, ok, 1'b1);
    cyc(1);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base_writes;
    bus.pix_valid = 1'b0;
    bus.pix_index = 8'h00;
    bus.rd_busy   = 1'b0;
    reset = 1'b1;
    cyc(4);
    @(negedge clock);
    chk("rst_wr", bus.sdram_wr, 1'b0);
    chk("rst_addr", bus.sdram_addr, 22'h0);
    chk("rst_data", bus.sdram_data, 128'h0);
    chk("rst_ready", bus.pix_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Stray acknowledge while idle must not start anything.
    stray_ac = 1;
    cyc(4);
    chk("stray_writes", writes, 0);
    chk("stray_busy", busy, 1'b0);

    // First word: ascending pixels 0x00..0x0F into buffer A.
    ac_min = 0; ac_max = 0;
    start_frame(1'b0, 1'b0);
    send_pixels(16, 1'b1, 1'b0);
    wait_writes("first_wait", 1);
    chk("first_addr", first_addr, 22'h100000);
    chk("first_data", first_data, 128'h0F0E0D0C0B0A09080706050403020100);
    chk("busy_fill", busy, 1'b1);
    ac_max = 3;
    send_pixels(T_PIX - 16, 1'b0, 1'b1);
    wait_idle("frame1_idle");
    chk("frame1_done", done_pulses, 1);
    chk("frame1_writes", writes, T_WORDS);
    chk("frame1_left", exp_q.size(), 0);

    // Whole frame into buffer B with prompt acknowledges.
    ac_min = 0; ac_max = 0;
    start_frame(1'b1, 1'b0);
    send_pixels(T_PIX, 1'b0, 1'b1);
    wait_idle("frame2_idle");
    chk("frame2_first", first_addr, BASE_B);
    chk("frame2_last", last_addr, BASE_B + fb_addr_t'(T_WORDS - 1));
    chk("frame2_writes", writes, 2 * T_WORDS);
    chk("frame2_done", done_pulses, 2);

    // rd_busy blocks new requests; four words fill the FIFO.
    base_writes = writes;
    start_frame(1'b0, 1'b0);
    bus.rd_busy = 1'b1;
    send_pixels(64, 1'b0, 1'b0);
    cyc(10);
    @(negedge clock);
    chk("fifo_full_ready", bus.pix_ready, 1'b0);
    chk("rd_busy_nowr", writes, base_writes);
    @(posedge clock);
    #1;
    // Slow acknowledge; rd_busy rises while the request is outstanding.
    ac_min = 10; ac_max = 10;
    bus.rd_busy = 1'b0;
    wait_flight("slow_req");
    bus.rd_busy = 1'b1;
    wait_writes("slow_done", base_writes + 1);
    cyc(5);
    chk("rd_busy_block", writes, base_writes + 1);
    ac_min = 0; ac_max = 2;
    bus.rd_busy = 1'b0;
    wait_writes("resume", base_writes + 4);
    chk("resume_left", exp_q.size(), 0);
    chk("resume_done", done_pulses, 2);

    // Restart with one request outstanding and one word queued.
    start_frame(1'b1, 1'b0);
    ac_min = 40; ac_max = 40;
    send_pixels(40, 1'b0, 1'b0);
    chk("restart_inflight", in_flight, 1'b1);
    chk("restart_queued", exp_q.size(), 1);
    base_writes = writes;
    ac_min = 0; ac_max = 3;
    start_frame(1'b0, 1'b0);
    send_pixels(T_PIX, 1'b0, 1'b1);
    wait_idle("frame3_idle");
    chk("restart_base", first_addr, BASE_A);
    chk("frame3_writes", writes, base_writes + T_WORDS);
    chk("frame3_done", done_pulses, 3);
    chk("frame3_left", exp_q.size(), 0);

`ifdef FB_PACK_WRITER_CLEAR_EN
    base_writes = writes;
    clear_color = 8'h2A;
    start_frame(1'b1, 1'b1);
    wait_idle("clear_idle");
    chk("clear_first", first_data, {16{8'h2A}});
    chk("clear_writes", writes, base_writes + T_WORDS);
    chk("clear_last", last_addr, BASE_B + fb_addr_t'(T_WORDS - 1));
    chk("clear_done", done_pulses, 4);
`endif

    cyc(5);
    chk("done_total", done_pulses,
`ifdef FB_PACK_WRITER_CLEAR_EN
        4
`else
        3
`endif
        );
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_pack_writer.md
# fb_pack_writer

Upstream producer for the scanline fetch stage. Accepts a raster-order stream of 8-bit palette indices from the renderer and packs 16 pixels into each 128-bit SDRAM word. Writes each packed word into the back frame buffer in SDRAM through a request/acknowledge port. The display fetch stage reads that buffer after the next `frame_flip`.

## Interface
- `BASE_A`, 22'h100000, frame buffer A base (word address)
- `BASE_B`, 22'h200000, frame buffer B base
- `WORDS_PER_LINE`, 40, 128-bit words per 640-pixel line
- `LINES`, 480, lines per frame
- `FIFO_DEPTH`, 4, packed-word FIFO entries (power of two)

Ports:
- `clock`  in  1  system clock
- `reset`  in  1  reset: synchronous, active-high; clock: clock
- `frame_flip`  in  1  display buffer select; 1 = display reads A, so this block writes B
- `frame_start`  in  1  one-cycle pulse; begin a frame
- `pix_valid`  in  1  pixel present
- `pix_index`  in  8  palette index
- `pix_ready`  out  1  pixel accepted when `pix_valid && pix_ready`
- `rd_busy`  in  1  display stage owns SDRAM; no new write request may start
- `sdram_wr`  out  1  write request
- `sdram_addr`  out  22  word address
- `sdram_data`  out  128  packed word
- `sdram_ac`  in  1  one-cycle acknowledge; word taken
- `busy`  out  1  frame in progress
- `frame_done`  out  1  one-cycle pulse after the last word is acknowledged

## Operation
- Input FSM states: `IDLE`, `FILL`, `DRAIN`, `DONE`.
  - `IDLE`/`DONE` to `FILL`: on `frame_start`.
    - Latch base: `frame_flip` ? `BASE_B` : `BASE_A`.
    - Clear pixel count `px` (0..15), word count `wx` (0..39) and line count `ly` (0..479).
  - `FILL` to `DRAIN`: when the final word (`ly`=479, `wx`=39) is pushed.
  - `DRAIN` to `DONE`: when the FIFO is empty and no request is outstanding. `frame_done` pulses on that transition.
- Packing: pixel `px` goes to bits [8*px+7 : 8*px], so pixel 0 sits in [7:0].
- On the 16th accepted pixel, push {addr, data} into the FIFO, with addr = base + `ly`*`WORDS_PER_LINE` + `wx`.
  - The multiply uses 22-bit arithmetic with no overflow check.
  - `wx` wraps 39 to 0 and increments `ly`.
- `pix_ready` = state is `FILL` && FIFO not full.
- Write FSM states: `WIDLE`, `WREQ`.
  - `WIDLE` to `WREQ`: FIFO not empty && `rd_busy` low. Load the head entry into `sdram_addr`/`sdram_data` and assert `sdram_wr`.
  - `WREQ`: hold `sdram_wr`, addr and data stable until `sdram_ac` is sampled high; `rd_busy` does not cancel a request in progress.
  - `WREQ` on `sdram_ac`: pop the FIFO and deassert `sdram_wr` (back to `WIDLE`). There is at least one idle cycle between requests.
- `busy` = state is `FILL` or `DRAIN`.
- `frame_start` during `FILL`/`DRAIN`: restart the frame.
  - Flush FIFO entries not yet requested, and discard the partial packer word.
  - An outstanding `WREQ` completes normally.
  - Re-latch the base.
  - No `frame_done` for the aborted frame.
- `sdram_ac` while in `WIDLE`: ignored.
- FIFO full while a 16th pixel arrives: cannot happen, because `pix_ready` is already low.

## Timing
- Reset values: `sdram_wr`=0, `sdram_addr`=0, `sdram_data`=0, `pix_ready`=0, `busy`=0, `frame_done`=0; both FSMs idle; FIFO empty.
- Reset mid-transaction drops `sdram_wr` on the next edge with no completion.
- Latency:
  - 16th pixel accepted at edge N: entry in FIFO at N.
  - `sdram_wr` high after edge N+1, provided `rd_busy` was low in cycle N+1.
- Throughput: one word per 2 cycles plus SDRAM wait.
- `frame_done` is registered: high for exactly the cycle after the state becomes `DONE`.
- All outputs are registered except `pix_ready`, which is combinational from state and FIFO count.

## Configuration
- `FB_PACK_WRITER_CLEAR_EN` defined:
  - Adds inputs `clear_req` (1) and `clear_color` (8).
  - `frame_start` with `clear_req`=1 runs a clear frame: `pix_ready` stays 0, and all 19200 words are generated internally as `clear_color` replicated 16 times.
  - Addressing, handshake and `frame_done` are the same as a normal frame.
- Undefined: ports absent; every frame consumes pixels.

## Structure
- Package `fb_pkg` holds:
  - `BASE_A`/`BASE_B`, `WORDS_PER_LINE`, `LINES`, `PIX_PER_WORD`=16
  - typedef `fb_word_t` (logic [127:0]), typedef `fb_addr_t` (logic [21:0])
  - FSM state enums
- Sub-module `fb_word_fifo`: synchronous FIFO with push, pop, flush, full and empty, holding {`fb_addr_t`, `fb_word_t`}.

## Test plan
- Reset, then `frame_start` with `frame_flip`=0 and 16 pixels 0x00..0x0F, `sdram_ac` 1 cycle after request -> `sdram_addr`=22'h100000, `sdram_data`=128'h0F0E…0100.
- `frame_flip`=1, full 307200-pixel frame, `ac` always prompt -> 19200 writes; last addr 22'h200000+479*40+39=22'h204AFF; one `frame_done` pulse.
- `rd_busy` held high for 50 cycles while the FIFO is filling -> no `sdram_wr`; after 4 words `pix_ready`=0; writes resume in order once `rd_busy` falls.
- `rd_busy` rising during `WREQ` and `ac` delayed 10 cycles -> addr/data stable for all 10 cycles; request completes.
- `frame_start` after 40 pixels with one request outstanding -> that request completes, the other queued word is never written, the next write is the new base; no `frame_done`.
- With `FB_PACK_WRITER_CLEAR_EN`, `clear_req`=1, `clear_color`=0x2A -> 19200 writes of 0x2A replicated 16 times, `pix_ready` stays 0, `frame_done` pulses once.
